// File: rtl/uart_cmd_pkg.sv
// Shared ASCII constants and parser state encoding for the UART command parser.
package uart_cmd_pkg;

  localparam logic [7:0] CHR_C   = 8'h43;
  localparam logic [7:0] CHR_c   = 8'h63;
  localparam logic [7:0] CHR_CR  = 8'h0D;
  localparam logic [7:0] CHR_LF  = 8'h0A;
  localparam logic [7:0] CHR_ESC = 8'h1B;
  localparam logic [7:0] CHR_0   = 8'h30;
  localparam logic [7:0] CHR_9   = 8'h39;

  typedef enum logic [1:0] {
    IDLE,
    CHAN,
    VALUE,
    DISCARD
  } state_t;

endpackage

// File: rtl/ascii_classify.sv
// Combinational byte classifier: decimal digits, command letter, line terminators, escape.
module ascii_classify
  import uart_cmd_pkg::*;
(
  input  logic [7:0] data,
  output logic       is_digit,
  output logic [3:0] digit,
  output logic       is_cmd,
  output logic       is_term,
  output logic       is_esc
);

  assign is_digit = (data >= CHR_0) && (data <= CHR_9);
  // ASCII '0'..'9' carry their value in the low nibble.
  assign digit    = data[3:0];
  assign is_cmd   = (data == CHR_C) || (data == CHR_c);
  assign is_term  = (data == CHR_CR) || (data == CHR_LF);
  assign is_esc   = (data == CHR_ESC);

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses "C<ch><value><CR|LF>" byte streams into a bank of PWM duty registers,
// with an optional single-digit legacy form on channel 0.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DUTY_W     = 7,
  parameter int MAX_DUTY   = 100,
  parameter int MAX_DIGITS = 3,
  parameter int LEGACY_EN  = 1,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [NUM_CH*DUTY_W-1:0] duty_cycle,
  output logic                     update_strobe,
  output logic [CH_W-1:0]          update_ch,
  output logic                     cmd_error
);

  localparam int ACC_W = $clog2(10 ** MAX_DIGITS);
  localparam int EXT_W = ACC_W + 4;
  localparam int CNT_W = 3;

  logic            is_digit, is_cmd, is_term, is_esc;
  logic [3:0]      digit;

  state_t          state, state_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic [EXT_W-1:0] acc_ext;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CH_W-1:0]  ch, ch_n;
  logic             wr_en, err_n;
  logic [CH_W-1:0]  wr_ch;
  logic [DUTY_W-1:0] wr_val;
  logic [DUTY_W-1:0] duty [NUM_CH];

  ascii_classify u_classify (
    .data     (rx_data),
    .is_digit (is_digit),
    .digit    (digit),
    .is_cmd   (is_cmd),
    .is_term  (is_term),
    .is_esc   (is_esc)
  );

  // Legacy single digit maps to digit*10, saturated at the largest legal duty.
  function automatic logic [DUTY_W-1:0] legacy_duty(input logic [3:0] d);
    int v;
    v = int'(d) * 10;
    if (v > MAX_DUTY) v = MAX_DUTY;
    return DUTY_W'(v);
  endfunction

  assign acc_ext = EXT_W'(acc) * EXT_W'(10) + EXT_W'(digit);

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    ch_n    = ch;
    wr_en   = 1'b0;
    wr_ch   = ch;
    wr_val  = DUTY_W'(acc);
    err_n   = 1'b0;
    if (rx_valid) begin
      if (is_esc) begin
        state_n = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (is_cmd) begin
              state_n = CHAN;
            end else if (is_digit && (LEGACY_EN != 0)) begin
              wr_en  = 1'b1;
              wr_ch  = '0;
              wr_val = legacy_duty(digit);
            end else if (!is_term) begin
              err_n   = 1'b1;
              state_n = DISCARD;
            end
          end
          CHAN: begin
            if (is_digit && (int'(digit) < NUM_CH)) begin
              ch_n    = CH_W'(digit);
              acc_n   = '0;
              cnt_n   = '0;
              state_n = VALUE;
            end else begin
              err_n   = 1'b1;
              state_n = is_term ? IDLE : DISCARD;
            end
          end
          VALUE: begin
            if (is_digit) begin
              // The digit limit also guarantees acc_ext fits back into ACC_W.
              if (int'(cnt) >= MAX_DIGITS) begin
                err_n   = 1'b1;
                state_n = DISCARD;
              end else begin
                acc_n = ACC_W'(acc_ext);
                cnt_n = cnt + CNT_W'(1);
              end
            end else if (is_term) begin
              state_n = IDLE;
              if ((cnt == '0) || (int'(acc) > MAX_DUTY)) begin
                err_n = 1'b1;
              end else begin
                wr_en = 1'b1;
              end
            end else begin
              err_n   = 1'b1;
              state_n = DISCARD;
            end
          end
          DISCARD: begin
            if (is_term) state_n = IDLE;
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      ch            <= '0;
      update_strobe <= 1'b0;
      update_ch     <= '0;
      cmd_error     <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) duty[k] <= '0;
    end else begin
      state         <= state_n;
      acc           <= acc_n;
      cnt           <= cnt_n;
      ch            <= ch_n;
      update_strobe <= wr_en;
      cmd_error     <= err_n;
      if (wr_en) update_ch <= wr_ch;
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_en && (wr_ch == CH_W'(k))) duty[k] <= wr_val;
      end
    end
  end

  always_comb begin
    duty_cycle = '0;
    for (int k = 0; k < NUM_CH; k++) duty_cycle[k*DUTY_W +: DUTY_W] = duty[k];
  end

endmodule
